tcp_ip_stack_core: RTL and testbench
====================================

# tcp_ip_stack_core

Bidirectional 32-bit word transport between the application side and the Ethernet MAC side of the trading datapath. Transmit words from the application are buffered and forwarded unchanged to the MAC. Receive words from the MAC are buffered and forwarded unchanged to the application. Each direction is an independent valid/ready stream with a small elastic buffer, so back-pressure on one side never stalls the other direction.

## Interface
- DEPTH, 4: entries per direction buffer; power of two, ≥2.
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- app_tx_data  in  32  application transmit word.
- app_tx_valid  in  1  app_tx_data valid.
- app_tx_ready  out  1  transmit buffer can accept.
- app_rx_data  out  32  received word to application.
- app_rx_valid  out  1  app_rx_data valid.
- app_rx_ready  in  1  application accepts.
- eth_tx_data  out  32  word to MAC.
- eth_tx_valid  out  1  eth_tx_data valid.
- eth_tx_ready  in  1  MAC accepts.
- eth_rx_data  in  32  word from MAC.
- eth_rx_valid  in  1  eth_rx_data valid.
- eth_rx_ready  out  1  receive buffer can accept.
- tx_csum, rx_csum  out  16  running checksums. Present only with TCP_IP_STACK_CSUM_EN.
- csum_clr  in  1  synchronous checksum clear. Present only with TCP_IP_STACK_CSUM_EN.

## Operation
- TX path: app_tx → FIFO → eth_tx. RX path: eth_rx → FIFO → app_rx. Data is never modified.
- Transfer occurs on a rising edge when valid && ready.
- Input ready = not full. Ready does not account for a same-cycle pop.
- Output valid = not empty. Output data = head entry (fall-through read of registered storage).
- Write and read pointers are log2(DEPTH)+1 bits wide.
  - Empty: pointers equal.
  - Full: MSBs differ and the remaining bits are equal.
  - Pointers wrap naturally.
- Push while full is impossible, because ready is low.
- Pop while empty is ignored, because valid is low.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves occupancy unchanged.
- Words exit in acceptance order. There is no loss or duplication.
- Output data is held stable while valid is high and ready is low.

## Timing
- Reset values:
  - all *_valid = 0
  - app_tx_ready = eth_rx_ready = 1
  - data outputs = 0
  - checksums = 0
  - pointers = 0
- Reset asserted mid-operation flushes both FIFOs immediately (asynchronous). Buffered words are discarded.
- Latency: a word accepted on edge N is presented with valid high immediately after edge N (1 cycle), provided the FIFO was empty.
- Throughput: one word per cycle per direction, sustained.
- Ready deasserts after the edge that writes the DEPTH-th entry. It reasserts after the first pop.

## Configuration
- TCP_IP_STACK_CSUM_EN defined:
  - Adds tx_csum, rx_csum and csum_clr.
  - Each checksum is the 16-bit ones'-complement sum of data[31:16] and data[15:0] of every word leaving its FIFO (output handshake). Carry is end-around.
  - Checksums update on the handshake edge.
  - csum_clr zeroes both; it has priority over a same-cycle update.
- Undefined: the ports and the logic are absent. Datapath behaviour is identical in both cases.

## Structure
- Package tcp_ip_stack_pkg holds:
  - DATA_W = 32
  - CSUM_W = 16
  - the ones'-complement add function
- The natural sub-module is stream_fifo (parameters DATA_W, DEPTH; valid/ready in and out). It is instantiated twice, for TX and RX.
- Checksum logic lives in the top level.

## Test plan
- Reset → all valids 0; app_tx_ready and eth_rx_ready 1; checksums 0.
- app_tx_data=0x12345678 for one cycle, eth_tx_ready=1 → next cycle eth_tx_valid=1 with eth_tx_data=0x12345678 for exactly one cycle; tx_csum=0x68AC (macro on).
- eth_rx_data=0x87654321 for one cycle, app_rx_ready=1 → next cycle app_rx_valid=1 with 0x87654321; rx_csum=0xCA86.
- eth_tx_ready=0; push 0xAAAAAAAA, 0xBBBBBBBB, 0xCCCCCCCC, 0xDDDDDDDD → app_tx_ready=0 after the 4th. Release ready → words emitted in order over 4 consecutive cycles; app_tx_ready returns to 1.
- Concurrent TX burst and RX burst (0x11111111, 0x22222222, 0x33333333) → both streams complete independently and in order.
- Assert rst_n low with 2 words buffered → valids drop immediately; after release no stale word appears.

Source files
------------

// File: rtl/tcp_ip_stack_pkg.sv
// Shared widths and the ones'-complement adder for the TCP/IP stack core.
package tcp_ip_stack_pkg;

    localparam int DATA_W = 32;
    localparam int CSUM_W = 16;

    // 16-bit ones'-complement addition with end-around carry.
    function automatic logic [CSUM_W-1:0] onesAdd(input logic [CSUM_W-1:0] a,
                                                   input logic [CSUM_W-1:0] b);
        logic [CSUM_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CSUM_W-1:0] + {{(CSUM_W-1){1'b0}}, sum[CSUM_W]};
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Valid/ready elastic buffer with fall-through read of registered storage.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module stream_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wrPtr_q, wrPtr_d;
    logic [AW:0]       rdPtr_q, rdPtr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // Occupancy flags from pointer comparison; ready ignores a same-cycle pop.
    always_comb begin
        empty       = (wrPtr_q == rdPtr_q);
        full        = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                      (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
        in_ready_o  = !full;
        out_valid_o = !empty;
        out_data_o  = mem_q[rdPtr_q[AW-1:0]];
        push        = in_valid_i && !full;
        pop         = out_ready_i && !empty;
        wrPtr_d     = push ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d     = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
    end

    // Pointer and storage registers; reset discards everything buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            if (push) begin
                mem_q[wrPtr_q[AW-1:0]] <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/tcp_ip_stack_core.sv
// Bidirectional word transport: app -> MAC (TX) and MAC -> app (RX), each
// through its own stream_fifo so the directions never stall each other.
// Optional running checksums of departing words: define TCP_IP_STACK_CSUM_EN.
module tcp_ip_stack_core
    import tcp_ip_stack_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] app_tx_data,
    input  logic              app_tx_valid,
    output logic              app_tx_ready,
    output logic [DATA_W-1:0] app_rx_data,
    output logic              app_rx_valid,
    input  logic              app_rx_ready,
    output logic [DATA_W-1:0] eth_tx_data,
    output logic              eth_tx_valid,
    input  logic              eth_tx_ready,
    input  logic [DATA_W-1:0] eth_rx_data,
    input  logic              eth_rx_valid,
    output logic              eth_rx_ready
`ifdef TCP_IP_STACK_CSUM_EN
    ,
    input  logic              csum_clr,
    output logic [CSUM_W-1:0] tx_csum,
    output logic [CSUM_W-1:0] rx_csum
`endif
);

    stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) txFifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data_i   (app_tx_data),
        .in_valid_i  (app_tx_valid),
        .in_ready_o  (app_tx_ready),
        .out_data_o  (eth_tx_data),
        .out_valid_o (eth_tx_valid),
        .out_ready_i (eth_tx_ready)
    );

    stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) rxFifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data_i   (eth_rx_data),
        .in_valid_i  (eth_rx_valid),
        .in_ready_o  (eth_rx_ready),
        .out_data_o  (app_rx_data),
        .out_valid_o (app_rx_valid),
        .out_ready_i (app_rx_ready)
    );

`ifdef TCP_IP_STACK_CSUM_EN
    logic [CSUM_W-1:0] txCsum_q, txCsum_d;
    logic [CSUM_W-1:0] rxCsum_q, rxCsum_d;

    // Fold both halves of each departing word in; clear wins over an update.
    always_comb begin
        txCsum_d = txCsum_q;
        rxCsum_d = rxCsum_q;
        if (csum_clr) begin
            txCsum_d = '0;
            rxCsum_d = '0;
        end else begin
            if (eth_tx_valid && eth_tx_ready) begin
                txCsum_d = onesAdd(onesAdd(txCsum_q, eth_tx_data[31:16]),
                                   eth_tx_data[15:0]);
            end
            if (app_rx_valid && app_rx_ready) begin
                rxCsum_d = onesAdd(onesAdd(rxCsum_q, app_rx_data[31:16]),
                                   app_rx_data[15:0]);
            end
        end
    end

    // Checksum registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txCsum_q <= '0;
            rxCsum_q <= '0;
        end else begin
            txCsum_q <= txCsum_d;
            rxCsum_q <= rxCsum_d;
        end
    end

    assign tx_csum = txCsum_q;
    assign rx_csum = rxCsum_q;
`endif

endmodule

// File: tb/tb_tcp_ip_stack_core.sv
// Testbench for tcp_ip_stack_core: queue-based reference model plus directed
// vectors. Checksum ports are exercised when TCP_IP_STACK_CSUM_EN is defined.
module tb_tcp_ip_stack_core;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] app_tx_data = '0;
    logic        app_tx_valid = 1'b0;
    logic        app_tx_ready;
    logic [31:0] app_rx_data;
    logic        app_rx_valid;
    logic        app_rx_ready = 1'b0;
    logic [31:0] eth_tx_data;
    logic        eth_tx_valid;
    logic        eth_tx_ready = 1'b0;
    logic [31:0] eth_rx_data = '0;
    logic        eth_rx_valid = 1'b0;
    logic        eth_rx_ready;
`ifdef TCP_IP_STACK_CSUM_EN
    logic        csum_clr = 1'b0;
    logic [15:0] tx_csum;
    logic [15:0] rx_csum;
`endif

    int vectorsApplied = 0;
    int miscompares = 0;
    bit checkEn = 1'b0;

    logic [31:0] txQ[$];
    logic [31:0] rxQ[$];
    logic [31:0] txSeen[$];
    logic [31:0] rxSeen[$];
    logic [15:0] txSum = '0;
    logic [15:0] rxSum = '0;

    tcp_ip_stack_core #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .app_tx_data  (app_tx_data),
        .app_tx_valid (app_tx_valid),
        .app_tx_ready (app_tx_ready),
        .app_rx_data  (app_rx_data),
        .app_rx_valid (app_rx_valid),
        .app_rx_ready (app_rx_ready),
        .eth_tx_data  (eth_tx_data),
        .eth_tx_valid (eth_tx_valid),
        .eth_tx_ready (eth_tx_ready),
        .eth_rx_data  (eth_rx_data),
        .eth_rx_valid (eth_rx_valid),
        .eth_rx_ready (eth_rx_ready)
`ifdef TCP_IP_STACK_CSUM_EN
        ,
        .csum_clr     (csum_clr),
        .tx_csum      (tx_csum),
        .rx_csum      (rx_csum)
`endif
    );

    always #5 clk = ~clk;

    // Ones'-complement sum of a word's halves into a running total, by folding.
    function automatic logic [15:0] addWord(input logic [15:0] acc, input logic [31:0] w);
        int unsigned s;
        s = acc + w[31:16] + w[15:0];
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return s[15:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic txValid, input logic [31:0] txData,
                                 input logic rxValid, input logic [31:0] rxData,
                                 input logic txReady, input logic rxReady);
        @(negedge clk);
        app_tx_valid = txValid;
        app_tx_data  = txData;
        eth_rx_valid = rxValid;
        eth_rx_data  = rxData;
        eth_tx_ready = txReady;
        app_rx_ready = rxReady;
    endtask

    // Reference model: each direction is a bounded queue; departures feed the sums.
    always @(posedge clk) begin
        if (rst_n) begin
            bit txPush, rxPush;
            txPush = app_tx_valid && (txQ.size() < DEPTH);
            rxPush = eth_rx_valid && (rxQ.size() < DEPTH);
            if (eth_tx_valid && eth_tx_ready) txSeen.push_back(eth_tx_data);
            if (app_rx_valid && app_rx_ready) rxSeen.push_back(app_rx_data);
            if (eth_tx_ready && txQ.size() > 0) begin
                logic [31:0] w;
                w = txQ.pop_front();
                txSum = addWord(txSum, w);
            end
            if (app_rx_ready && rxQ.size() > 0) begin
                logic [31:0] w;
                w = rxQ.pop_front();
                rxSum = addWord(rxSum, w);
            end
`ifdef TCP_IP_STACK_CSUM_EN
            if (csum_clr) begin
                txSum = '0;
                rxSum = '0;
            end
`endif
            if (txPush) txQ.push_back(app_tx_data);
            if (rxPush) rxQ.push_back(eth_rx_data);
        end
    end

    // Reset discards every buffered word and the running sums.
    always @(negedge rst_n) begin
        txQ.delete();
        rxQ.delete();
        txSum = '0;
        rxSum = '0;
    end

    // Per-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (rst_n && checkEn) begin
            checkOutput("ethTxValid", {31'b0, eth_tx_valid}, {31'b0, txQ.size() != 0});
            if (txQ.size() != 0) checkOutput("ethTxData", eth_tx_data, txQ[0]);
            checkOutput("appTxReady", {31'b0, app_tx_ready}, {31'b0, txQ.size() < DEPTH});
            checkOutput("appRxValid", {31'b0, app_rx_valid}, {31'b0, rxQ.size() != 0});
            if (rxQ.size() != 0) checkOutput("appRxData", app_rx_data, rxQ[0]);
            checkOutput("ethRxReady", {31'b0, eth_rx_ready}, {31'b0, rxQ.size() < DEPTH});
`ifdef TCP_IP_STACK_CSUM_EN
            checkOutput("txCsum", {16'b0, tx_csum}, {16'b0, txSum});
            checkOutput("rxCsum", {16'b0, rx_csum}, {16'b0, rxSum});
`endif
        end
    end

    initial begin
        logic [31:0] burst[4];
        burst[0] = 32'hAAAAAAAA;
        burst[1] = 32'hBBBBBBBB;
        burst[2] = 32'hCCCCCCCC;
        burst[3] = 32'hDDDDDDDD;

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        checkOutput("rstEthTxValid", {31'b0, eth_tx_valid}, 32'd0);
        checkOutput("rstAppRxValid", {31'b0, app_rx_valid}, 32'd0);
        checkOutput("rstAppTxReady", {31'b0, app_tx_ready}, 32'd1);
        checkOutput("rstEthRxReady", {31'b0, eth_rx_ready}, 32'd1);
        checkOutput("rstEthTxData", eth_tx_data, 32'd0);
        checkOutput("rstAppRxData", app_rx_data, 32'd0);
`ifdef TCP_IP_STACK_CSUM_EN
        checkOutput("rstTxCsum", {16'b0, tx_csum}, 32'd0);
        checkOutput("rstRxCsum", {16'b0, rx_csum}, 32'd0);
`endif
        rst_n = 1'b1;
        checkEn = 1'b1;

        // Single TX word, one-cycle latency, present for exactly one cycle.
        applyStimulus(1, 32'h12345678, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("txSingleValid", {31'b0, eth_tx_valid}, 32'd1);
        checkOutput("txSingleData", eth_tx_data, 32'h12345678);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("txSingleGone", {31'b0, eth_tx_valid}, 32'd0);
`ifdef TCP_IP_STACK_CSUM_EN
        checkOutput("txSingleCsum", {16'b0, tx_csum}, 32'h68AC);
`endif

        // Single RX word.
        applyStimulus(0, 0, 1, 32'h87654321, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("rxSingleValid", {31'b0, app_rx_valid}, 32'd1);
        checkOutput("rxSingleData", app_rx_data, 32'h87654321);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("rxSingleGone", {31'b0, app_rx_valid}, 32'd0);
`ifdef TCP_IP_STACK_CSUM_EN
        checkOutput("rxSingleCsum", {16'b0, rx_csum}, 32'hCA86);
        csum_clr = 1'b1;
        applyStimulus(0, 0, 0, 0, 1, 1);
        csum_clr = 1'b0;
        checkOutput("csumClrTx", {16'b0, tx_csum}, 32'd0);
        checkOutput("csumClrRx", {16'b0, rx_csum}, 32'd0);
`endif

        // Fill TX while the MAC stalls, then drain in order.
        for (int i = 0; i < 4; i++) applyStimulus(1, burst[i], 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("txFullReady", {31'b0, app_tx_ready}, 32'd0);
        checkOutput("txFullHeld", eth_tx_data, 32'hAAAAAAAA);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 1);
            checkOutput("txDrainValid", {31'b0, eth_tx_valid}, 32'd1);
            checkOutput("txDrainData", eth_tx_data, burst[i]);
            if (i == 1) checkOutput("txReadyBack", {31'b0, app_tx_ready}, 32'd1);
        end
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("txDrainEmpty", {31'b0, eth_tx_valid}, 32'd0);

        // Concurrent bursts, RX side with intermittent back-pressure.
        txSeen.delete();
        rxSeen.delete();
        for (int i = 1; i <= 3; i++) applyStimulus(1, 32'h11111111 * i, 1, 32'h11111111 * i, 1, i[0]);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1, i[0]);
        checkOutput("concTxCount", txSeen.size(), 32'd3);
        checkOutput("concRxCount", rxSeen.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < txSeen.size()) checkOutput("concTxOrder", txSeen[i], 32'h11111111 * (i + 1));
            if (i < rxSeen.size()) checkOutput("concRxOrder", rxSeen[i], 32'h11111111 * (i + 1));
        end

        // Asynchronous reset with two words buffered in each direction.
        applyStimulus(1, 32'h0BADF00D, 1, 32'h0BADF00D, 0, 0);
        applyStimulus(1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkEn = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncRstTxValid", {31'b0, eth_tx_valid}, 32'd0);
        checkOutput("asyncRstRxValid", {31'b0, app_rx_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        checkEn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 1);
            checkOutput("postRstTxValid", {31'b0, eth_tx_valid}, 32'd0);
            checkOutput("postRstRxValid", {31'b0, app_rx_valid}, 32'd0);
        end

        @(negedge clk);
        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
